// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus frame receiver.
//   - Frame geometry: start bit + src + dst + mod + data + crc = 79 bits.
//   - CRC-4 polynomial x^4+x+1 and a single-bit update helper.
//   - Mode encodings and the receiver FSM state type.
package bus_pkg;

  localparam int FRAME_BITS   = 79;
  localparam int ADDR_W       = 4;
  localparam int MOD_W        = 2;
  localparam int DATA_W       = 64;
  localparam int CRC_W        = 4;

  // Bits covered by the CRC: src, dst, mod and data.
  localparam int PAYLOAD_BITS = 2 * ADDR_W + MOD_W + DATA_W;

  localparam logic [CRC_W-1:0] CRC_POLY    = 4'b0011;
  localparam logic [MOD_W-1:0] MOD_UNICAST = 2'b00;
  localparam logic [MOD_W-1:0] MOD_BCAST   = 2'b01;

  // Bit counter runs 0..77 across the header, data and CRC fields.
  localparam int            BIT_CNT_W = 7;
  localparam logic [BIT_CNT_W-1:0] HDR_LAST  = 7'd9;
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = 7'd73;
  localparam logic [BIT_CNT_W-1:0] CRC_LAST  = 7'd77;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CRC
  } rx_state_t;

  // One MSB-first step of the CRC-4 LFSR.
  function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] crc,
                                                 input logic             bit_in);
    logic fb;
    fb = crc[CRC_W-1] ^ bit_in;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc4_serial.sv
// Serial CRC-4 (x^4+x+1, init 0), one bit per enabled clock.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset, clears the remainder
//   clear   - restart the remainder at 0 (wins over enable)
//   enable  - fold bit_in into the remainder this cycle
//   bit_in  - serial data bit, MSB first
//   crc     - current remainder
module crc4_serial
  import bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;

  // NOTE: combinational next-state uses blocking '=' with a default first,
  // so every path assigns crc_d and no latch is inferred.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = crc4_step(crc_q, bit_in);
    end
  end

  // NOTE: state registers use non-blocking '<=' so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/bus_frame_receiver.sv
// Serial bus frame receiver: deframes 79-bit packets from a single-bit line,
// checks the CRC, filters by destination/mode and strobes accepted frames.
// Configuration macro: BUS_RX_CRC_CHECK_EN
//   defined   - CRC field is compared against a serially computed CRC-4
//   undefined - CRC field is consumed but ignored, crc_err tied low
// Parameters:
//   MY_ADDR    - this node's address
//   CNT_W      - width of the saturating accepted-frame counter
// Ports:
//   clock       - rising-edge clock, bus_in sampled here
//   reset       - synchronous active-high reset
//   bus_in      - serial line, idles low, start bit is 1
//   frame_valid - one-cycle pulse on an accepted frame
//   src_addr    - sender of the last accepted frame
//   rx_mod      - mode of the last accepted frame
//   rx_data     - data of the last accepted frame
//   crc_err     - one-cycle pulse on a CRC mismatch
//   addr_drop   - one-cycle pulse on a good frame not for this node
//   frame_cnt   - saturating count of accepted frames
module bus_frame_receiver
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MY_ADDR = 4'd0,
  parameter int                CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_in,
  output logic              frame_valid,
  output logic [ADDR_W-1:0] src_addr,
  output logic [MOD_W-1:0]  rx_mod,
  output logic [DATA_W-1:0] rx_data,
  output logic              crc_err,
  output logic              addr_drop,
  output logic [CNT_W-1:0]  frame_cnt
);

  rx_state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0]   payload_q, payload_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      addr_drop_q, addr_drop_d;
  logic [ADDR_W-1:0]         src_q, src_d;
  logic [MOD_W-1:0]          mod_q, mod_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  // Field views of the shifted-in payload (src is oldest, data LSB newest).
  logic [ADDR_W-1:0] f_src;
  logic [ADDR_W-1:0] f_dst;
  logic [MOD_W-1:0]  f_mod;
  logic [DATA_W-1:0] f_data;
  logic              crc_bad;
  logic              accept;

  assign f_src  = payload_q[PAYLOAD_BITS-1 -: ADDR_W];
  assign f_dst  = payload_q[PAYLOAD_BITS-1-ADDR_W -: ADDR_W];
  assign f_mod  = payload_q[DATA_W +: MOD_W];
  assign f_data = payload_q[DATA_W-1:0];

`ifdef BUS_RX_CRC_CHECK_EN
  logic [CRC_W-2:0] crc_rx_q, crc_rx_d;
  logic             crc_err_q, crc_err_d;
  logic [CRC_W-1:0] crc_calc;

  crc4_serial u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state_q == IDLE) && bus_in),
    .enable ((state_q == HDR) || (state_q == DATA)),
    .bit_in (bus_in),
    .crc    (crc_calc)
  );

  // The last CRC bit is still on bus_in when the frame is evaluated.
  assign crc_bad = ({crc_rx_q, bus_in} != crc_calc);
  assign crc_err = crc_err_q;
`else
  assign crc_bad = 1'b0;
  assign crc_err = 1'b0;
`endif

  assign accept = !crc_bad &&
                  (((f_mod == MOD_UNICAST) && (f_dst == MY_ADDR)) ||
                   (f_mod == MOD_BCAST));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    payload_d     = payload_q;
    frame_valid_d = 1'b0;
    addr_drop_d   = 1'b0;
    src_d         = src_q;
    mod_d         = mod_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
`ifdef BUS_RX_CRC_CHECK_EN
    crc_rx_d      = crc_rx_q;
    crc_err_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus_in) begin
          state_d   = HDR;
          bit_cnt_d = '0;
        end
      end
      HDR: begin
        payload_d = {payload_q[PAYLOAD_BITS-2:0], bus_in};
        bit_cnt_d = bit_cnt_q + 7'd1;
        if (bit_cnt_q == HDR_LAST) state_d = DATA;
      end
      DATA: begin
        payload_d = {payload_q[PAYLOAD_BITS-2:0], bus_in};
        bit_cnt_d = bit_cnt_q + 7'd1;
        if (bit_cnt_q == DATA_LAST) state_d = CRC;
      end
      CRC: begin
        bit_cnt_d = bit_cnt_q + 7'd1;
`ifdef BUS_RX_CRC_CHECK_EN
        crc_rx_d  = {crc_rx_q[CRC_W-3:0], bus_in};
`endif
        if (bit_cnt_q == CRC_LAST) begin
          state_d = IDLE;
          if (crc_bad) begin
`ifdef BUS_RX_CRC_CHECK_EN
            crc_err_d = 1'b1;
`endif
          end else if (accept) begin
            frame_valid_d = 1'b1;
            src_d         = f_src;
            mod_d         = f_mod;
            data_d        = f_data;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end else begin
            addr_drop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      addr_drop_q   <= 1'b0;
      src_q         <= '0;
      mod_q         <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
`ifdef BUS_RX_CRC_CHECK_EN
      crc_rx_q      <= '0;
      crc_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_valid_q <= frame_valid_d;
      addr_drop_q   <= addr_drop_d;
      src_q         <= src_d;
      mod_q         <= mod_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
`ifdef BUS_RX_CRC_CHECK_EN
      crc_rx_q      <= crc_rx_d;
      crc_err_q     <= crc_err_d;
`endif
    end
  end

  // NOTE: the payload shift register is pure datapath and is left unreset;
  // it is fully rewritten by every frame before any field is consumed.
  always_ff @(posedge clock) begin
    payload_q <= payload_d;
  end

  assign frame_valid = frame_valid_q;
  assign addr_drop   = addr_drop_q;
  assign src_addr    = src_q;
  assign rx_mod      = mod_q;
  assign rx_data     = data_q;
  assign frame_cnt   = cnt_q;

endmodule
